// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: control bundle, NOP constant and ID/EX payload.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;

  typedef struct packed {
    logic               regw;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
    logic              valid;
  } idex_t;

  // All-zero payload: invalid, NOP control, x0 addresses, so it can never look like a load.
  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: ID reads a register that the load in EX has yet to write.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic              valid_ex,
  input  logic              memread_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic              valid_id,
  output logic              hazard
);

  logic src_match;

  // A doubled source (rs1==rs2==rd) still reduces to one hazard bit, hence one stall.
  assign src_match = (use_rs1_id && (rs1_id == rd_ex)) ||
                     (use_rs2_id && (rs2_id == rd_ex));

  assign hazard = valid_ex && memread_ex && (rd_ex != '0) && src_match && valid_id;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion, flush/hold priority and stall counter.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  ctrl_t             ctrl_id,
  input  logic              valid_id,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [XLEN-1:0]   pc_ex,
  output logic [XLEN-1:0]   rs1_data_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [REG_AW-1:0] rs1_ex,
  output logic [REG_AW-1:0] rs2_ex,
  output logic [REG_AW-1:0] rd_ex,
  output ctrl_t             ctrl_ex,
  output logic              valid_ex,
  output logic              stall_o,
  output logic [XLEN-1:0]   stall_cnt
);

  idex_t           ex_q, ex_d, id_in;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic            hazard;

  hazard_detect u_hazard_detect (
    .valid_ex   (ex_q.valid),
    .memread_ex (ex_q.ctrl.memread),
    .rd_ex      (ex_q.rd),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .valid_id   (valid_id),
    .hazard     (hazard)
  );

  // Flush and hold both mask the stall: a killed or frozen instruction is not waiting on data.
  assign stall_o = hazard && !flush_i && !hold_i;

  always_comb begin
    id_in.pc       = pc_id;
    id_in.rs1_data = rs1_data_id;
    id_in.rs2_data = rs2_data_id;
    id_in.imm      = imm_id;
    id_in.rs1      = rs1_id;
    id_in.rs2      = rs2_id;
    id_in.rd       = rd_id;
    id_in.ctrl     = valid_id ? ctrl_id : CTRL_NOP;
    id_in.valid    = valid_id;
  end

  // Next-state priority below reset: flush > hold > hazard > normal load.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      ex_d = IDEX_BUBBLE;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = IDEX_BUBBLE;
    end else begin
      ex_d = id_in;
    end
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= IDEX_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_ex       = ex_q.pc;
  assign rs1_data_ex = ex_q.rs1_data;
  assign rs2_data_ex = ex_q.rs2_data;
  assign imm_ex      = ex_q.imm;
  assign rs1_ex      = ex_q.rs1;
  assign rs2_ex      = ex_q.rs2;
  assign rd_ex       = ex_q.rd;
  assign ctrl_ex     = ex_q.ctrl;
  assign valid_ex    = ex_q.valid;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, load-use stall, flush, hold, saturation, reset.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        use_rs1_id, use_rs2_id;
  ctrl_t       ctrl_id;
  logic        valid_id, flush_i, hold_i;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  ctrl_t       ctrl_ex;
  logic        valid_ex, stall_o;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // regw,memread,memwrite,memtoreg,alusrc,branch,jump,aluop[3:0]
  localparam ctrl_t C_LW  = ctrl_t'(11'b110_1100_0000);
  localparam ctrl_t C_ADD = ctrl_t'(11'b100_0000_0010);

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .pc_id(pc_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .ctrl_id(ctrl_id), .valid_id(valid_id), .flush_i(flush_i), .hold_i(hold_i),
    .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .ctrl_ex(ctrl_ex), .valid_ex(valid_ex), .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input ctrl_t c, input logic v);
    pc_id       = pc;
    rs1_data_id = 32'h1000_0000 | pc;
    rs2_data_id = 32'h2000_0000 | pc;
    imm_id      = 32'h3000_0000 | pc;
    rs1_id      = rs1;
    rs2_id      = rs2;
    rd_id       = rd;
    use_rs1_id  = u1;
    use_rs2_id  = u2;
    ctrl_id     = c;
    valid_id    = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_id(32'hDEAD_0000, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, C_LW, 1'b1);
    tick();
    tick();
    n_cmp++; if (valid_ex !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_ex); end
    n_cmp++; if (ctrl_ex !== CTRL_NOP) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", ctrl_ex); end
    n_cmp++; if (pc_ex !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_ex); end
    n_cmp++; if (rd_ex !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", rd_ex); end
    n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_id(32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    n_cmp++; if (ctrl_ex !== C_LW || rd_ex !== 5'd5 || valid_ex !== 1'b1) begin
      n_err++; $display("FAIL lu_lw_capture: got ctrl=%h rd=%0d v=%b want %h 5 1", ctrl_ex, rd_ex, valid_ex, C_LW); end
    @(negedge clk);
    drive_id(32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall_o); end
    tick();
    n_cmp++; if (ctrl_ex !== CTRL_NOP || valid_ex !== 1'b0 || rd_ex !== 5'd0 || pc_ex !== 32'h0) begin
      n_err++; $display("FAIL lu_bubble: got ctrl=%h v=%b rd=%0d pc=%h want 0 0 0 0", ctrl_ex, valid_ex, rd_ex, pc_ex); end
    n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_one_stall: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (pc_ex !== 32'h104 || rd_ex !== 5'd6 || ctrl_ex !== C_ADD || valid_ex !== 1'b1) begin
      n_err++; $display("FAIL lu_add_capture: got pc=%h rd=%0d ctrl=%h v=%b want 104 6 %h 1", pc_ex, rd_ex, ctrl_ex, valid_ex, C_ADD); end
    n_cmp++; if (rs1_ex !== 5'd5 || rs2_ex !== 5'd7 || rs1_data_ex !== 32'h1000_0104 ||
                 rs2_data_ex !== 32'h2000_0104 || imm_ex !== 32'h3000_0104) begin
      n_err++; $display("FAIL lu_add_data: got rs1=%0d rs2=%0d d1=%h d2=%h imm=%h", rs1_ex, rs2_ex, rs1_data_ex, rs2_data_ex, imm_ex); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    drive_id(32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h204, 5'd0, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL x0_no_stall: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (pc_ex !== 32'h204 || valid_ex !== 1'b1 || stall_cnt !== 32'd1) begin
      n_err++; $display("FAIL x0_capture: got pc=%h v=%b cnt=%0d want 204 1 1", pc_ex, valid_ex, stall_cnt); end
  endtask

  task automatic test_same_reg();
    @(negedge clk);
    drive_id(32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h304, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL same_stall: got %b want 1", stall_o); end
    tick();
    n_cmp++; if (stall_cnt !== 32'd2 || valid_ex !== 1'b0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL same_single: got cnt=%0d v=%b stall=%b want 2 0 0", stall_cnt, valid_ex, stall_o); end
    tick();
    n_cmp++; if (pc_ex !== 32'h304 || stall_cnt !== 32'd2) begin
      n_err++; $display("FAIL same_capture: got pc=%h cnt=%0d want 304 2", pc_ex, stall_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive_id(32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h404, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD, 1'b1);
    flush_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_no_stall: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (valid_ex !== 1'b0 || ctrl_ex !== CTRL_NOP || pc_ex !== 32'h0 || stall_cnt !== 32'd2) begin
      n_err++; $display("FAIL flush_bubble: got v=%b ctrl=%h pc=%h cnt=%0d want 0 0 0 2", valid_ex, ctrl_ex, pc_ex, stall_cnt); end
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_hold();
    drive_id(32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    n_cmp++; if (pc_ex !== 32'h100) begin n_err++; $display("FAIL hold_preload: got %h want 100", pc_ex); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hold_i = 1'b1;
      drive_id(32'h500 + 32'(4 * i), 5'd5, 5'd9, 5'd10 + 5'(i), 1'b1, 1'b1, C_ADD, 1'b1);
      #1;
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL hold_no_stall%0d: got %b want 0", i, stall_o); end
      tick();
      n_cmp++; if (pc_ex !== 32'h100 || ctrl_ex !== C_LW || valid_ex !== 1'b1 || rd_ex !== 5'd5 ||
                   imm_ex !== 32'h3000_0100 || stall_cnt !== 32'd2) begin
        n_err++; $display("FAIL hold_frozen%0d: got pc=%h ctrl=%h v=%b rd=%0d imm=%h cnt=%0d", i, pc_ex, ctrl_ex, valid_ex, rd_ex, imm_ex, stall_cnt); end
    end
    @(negedge clk);
    hold_i = 1'b0;
    drive_id(32'h600, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_ADD, 1'b0);
  endtask

  task automatic test_invalid();
    tick();
    n_cmp++; if (valid_ex !== 1'b0 || ctrl_ex !== CTRL_NOP || pc_ex !== 32'h600 || rd_ex !== 5'd9) begin
      n_err++; $display("FAIL invalid_nop: got v=%b ctrl=%h pc=%h rd=%0d want 0 0 600 9", valid_ex, ctrl_ex, pc_ex, rd_ex); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    n_cmp++; if (stall_cnt !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sat_preload: got %h want FFFFFFFE", stall_cnt); end
    drive_id(32'h700, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h704, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD, 1'b1);
    tick();
    n_cmp++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_max: got %h want FFFFFFFF", stall_cnt); end
    drive_id(32'h708, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h70C, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, C_ADD, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL sat_stall: got %b want 1", stall_o); end
    tick();
    n_cmp++; if (stall_cnt !== 32'hFFFF_FFFF || valid_ex !== 1'b0) begin
      n_err++; $display("FAIL sat_hold: got cnt=%h v=%b want FFFFFFFF 0", stall_cnt, valid_ex); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive_id(32'h800, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW, 1'b1);
    tick();
    drive_id(32'h804, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1", stall_o); end
    reset = 1'b1;
    tick();
    n_cmp++; if (valid_ex !== 1'b0 || ctrl_ex !== CTRL_NOP || rd_ex !== 5'd0 || stall_cnt !== 32'h0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_stall: got v=%b ctrl=%h rd=%0d cnt=%h stall=%b want 0 0 0 0 0", valid_ex, ctrl_ex, rd_ex, stall_cnt, stall_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    drive_id(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_NOP, 1'b0);
    test_reset();
    test_load_use();
    test_x0();
    test_same_reg();
    test_flush();
    test_hold();
    test_invalid();
    test_saturate();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
